// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial frame receiver:
//   state_t        - receive FSM states
//   START_BIT      - line level that opens a frame
//   STOP_BIT       - line level that must close a good frame
//   DIR_MSB_FIRST  - dir value: first data bit is the word's MSB
//   DIR_LSB_FIRST  - dir value: first data bit is the word's LSB
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // The line idles low, so a high bit is the only way to open a frame.
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver_if
// One-entry valid/ready output channel of the serial frame receiver.
//   data_out   - assembled word, stable while data_valid is high
//   data_valid - the buffer holds an unread word
//   data_ready - consumer accepts the word when data_valid && data_ready
// Modports:
//   master - the receiver side (drives data_out/data_valid)
//   slave  - the consumer side (drives data_ready)
// -----------------------------------------------------------------------------
interface serial_frame_receiver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_frame_receiver_rx_hold_buf.sv
// -----------------------------------------------------------------------------
// rx_hold_buf
// One-entry holding register between the receive FSM and the consumer.
// A committed word is loaded when the buffer is empty or is being drained in
// the same cycle; otherwise the word is dropped and the sticky overrun flag is
// raised. Overrun is cleared by clear_err_i, but a new drop in the same cycle
// keeps it set.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   commit_i     - a good frame is complete this cycle
//   word_i       - the completed frame's data
//   clear_err_i  - clears the overrun flag
//   overrun_o    - sticky overrun flag
//   out_if       - valid/ready output channel (master side)
// -----------------------------------------------------------------------------
module rx_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             clear_err_i,
    output logic             overrun_o,
    serial_frame_receiver_if.master out_if
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;

    logic drain;
    logic load;
    logic drop;

    // NOTE: each always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        drain = valid_q && out_if.data_ready;
        load  = commit_i && (!valid_q || drain);
        drop  = commit_i && valid_q && !drain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data register is reset as well, so data_out reads 0
            // after reset rather than a stale word.
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= word_i;
                valid_q <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end

            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_err_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign out_if.data_out   = data_q;
    assign out_if.data_valid = valid_q;
    assign overrun_o         = overrun_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
// Receives frames from a serial bit stream: start bit (1), WIDTH data bits
// (MSB- or LSB-first, chosen by dir at the start bit), an optional even parity
// bit, and a stop bit (0). Good frames are handed to a one-entry valid/ready
// buffer one cycle after the stop-bit strobe.
// Build option: define PARITY_CHECK_EN to insert and check the parity bit.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   bit_valid  - in_bit carries a new serial bit this cycle
//   in_bit     - serial data
//   dir        - 0 = MSB-first, 1 = LSB-first (sampled at the start bit)
//   clear_err  - clears overrun
//   frame_err  - one-cycle pulse: stop bit was 1
//   overrun    - sticky: a good frame was dropped because the buffer was full
//   parity_err - one-cycle pulse on parity mismatch (0 without PARITY_CHECK_EN)
//   out_if     - valid/ready output channel (data_out/data_valid/data_ready)
// -----------------------------------------------------------------------------
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_valid,
    input  logic in_bit,
    input  logic dir,
    input  logic clear_err,
    output logic frame_err,
    output logic overrun,
    output logic parity_err,
    serial_frame_receiver_if.master out_if
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] shift_q;
    logic             dir_q;
    logic             frame_err_q;
`ifdef PARITY_CHECK_EN
    logic             parity_bad_q;
    logic             parity_err_q;
`endif

    logic stop_strobe;
    logic good_frame;

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            dir_q       <= DIR_MSB_FIRST;
            frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Error flags are pulses: low unless the STOP decision raises them.
            frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            if (bit_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (in_bit == START_BIT) begin
                            state_q <= ST_DATA;
                            count_q <= '0;
                            shift_q <= '0;
                            dir_q   <= dir;
                        end
                    end
                    ST_DATA: begin
                        if (dir_q == DIR_LSB_FIRST) begin
                            shift_q <= {in_bit, shift_q[WIDTH-1:1]};
                        end else begin
                            shift_q <= {shift_q[WIDTH-2:0], in_bit};
                        end
                        if (count_q == LAST_BIT) begin
                            count_q <= '0;
`ifdef PARITY_CHECK_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
`ifdef PARITY_CHECK_EN
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        parity_bad_q <= (in_bit != ^shift_q);
                        state_q      <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        frame_err_q <= (in_bit != STOP_BIT);
`ifdef PARITY_CHECK_EN
                        parity_err_q <= parity_bad_q;
`endif
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign stop_strobe = (state_q == ST_STOP) && bit_valid;

`ifdef PARITY_CHECK_EN
    assign good_frame = stop_strobe && (in_bit == STOP_BIT) && !parity_bad_q;
    assign parity_err = parity_err_q;
`else
    assign good_frame = stop_strobe && (in_bit == STOP_BIT);
    assign parity_err = 1'b0;
`endif

    assign frame_err = frame_err_q;

    // The buffer registers the commit on the stop-strobe edge, so data_valid
    // rises one cycle after the strobe.
    rx_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .commit_i   (good_frame),
        .word_i     (shift_q),
        .clear_err_i(clear_err),
        .overrun_o  (overrun),
        .out_if     (out_if)
    );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_receiver
// Self-checking bench for serial_frame_receiver (WIDTH = 8). Honours
// PARITY_CHECK_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver;
    import serial_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    logic bit_valid;
    logic in_bit;
    logic dir;
    logic clear_err;
    logic frame_err;
    logic overrun;
    logic parity_err;

`ifdef PARITY_CHECK_EN
    logic par_flip = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] sb_q[$];

    typedef struct {
        string            name;
        logic             dir;
        logic [WIDTH-1:0] word;
        logic             stop;
        logic             toggle;
        int               gap;
        logic             exp_valid;
        logic             exp_ferr;
    } vec_t;

    vec_t vecs[9];

    serial_frame_receiver_if #(.WIDTH(WIDTH)) out_if ();

    serial_frame_receiver #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .in_bit    (in_bit),
        .dir       (dir),
        .clear_err (clear_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .out_if    (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Pops the next expected word and compares it with data_out.
    task automatic expect_word(input string name);
        logic [WIDTH-1:0] exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got word 0x%0h, required nothing (scoreboard empty)", name, out_if.data_out);
        end else begin
            exp = sb_q.pop_front();
            check(name, 32'(out_if.data_out), 32'(exp));
        end
    endtask

    // One strobed bit followed by `gap` idle cycles; returns on a negedge.
    task automatic drive_bit(input logic b, input int gap);
        @(negedge clk);
        bit_valid = 1'b1;
        in_bit    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        in_bit    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends a whole frame. data_ready and clear_err take the given values in
    // the stop-bit cycle. Returns on the negedge right after the stop strobe.
    task automatic send_frame(input logic dir_v, input logic [WIDTH-1:0] word,
                              input logic stop_v, input logic toggle, input int gap,
                              input logic rdy_stop, input logic clr_stop);
        dir = dir_v;
        drive_bit(START_BIT, gap);
        for (int i = 0; i < WIDTH; i++) begin
            if (toggle && i == 3) dir = ~dir;
            drive_bit(word[dir_v ? i : WIDTH - 1 - i], gap);
        end
`ifdef PARITY_CHECK_EN
        drive_bit((^word) ^ par_flip, gap);
`endif
        @(negedge clk);
        bit_valid         = 1'b1;
        in_bit            = stop_v;
        out_if.data_ready = rdy_stop;
        clear_err         = clr_stop;
        @(negedge clk);
        bit_valid = 1'b0;
        in_bit    = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        vec_t v;

        //          name            dir   word   stop  tog   gap exp_v exp_fe
        vecs[0] = '{"msb_a5",       1'b0, 8'hA5, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{"lsb_ac_tog",   1'b1, 8'hAC, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        vecs[2] = '{"bad_stop",     1'b0, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[3] = '{"after_bad_3c", 1'b0, 8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[4] = '{"gap_msb_80",   1'b0, 8'h80, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[5] = '{"gap_lsb_01",   1'b1, 8'h01, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        vecs[6] = '{"msb_ff",       1'b0, 8'hFF, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[7] = '{"lsb_00",       1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[8] = '{"bad_stop_lsb", 1'b1, 8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b1};

        reset             = 1'b1;
        bit_valid         = 1'b0;
        in_bit            = 1'b0;
        dir               = 1'b0;
        clear_err         = 1'b0;
        out_if.data_ready = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst/data_out",   32'(out_if.data_out), 32'h0);
        check("rst/data_valid", 32'(out_if.data_valid), 32'h0);
        check("rst/frame_err",  32'(frame_err), 32'h0);
        check("rst/overrun",    32'(overrun), 32'h0);
        check("rst/parity_err", 32'(parity_err), 32'h0);
        reset = 1'b0;

        // ---- table-driven frames, consumer always ready ----
        out_if.data_ready = 1'b1;
        foreach (vecs[k]) begin
            v = vecs[k];
            if (v.exp_valid) sb_q.push_back(v.word);
            send_frame(v.dir, v.word, v.stop, v.toggle, v.gap, 1'b1, 1'b0);
            check({v.name, "/valid"},      32'(out_if.data_valid), 32'(v.exp_valid));
            check({v.name, "/frame_err"},  32'(frame_err), 32'(v.exp_ferr));
            check({v.name, "/overrun"},    32'(overrun), 32'h0);
            check({v.name, "/parity_err"}, 32'(parity_err), 32'h0);
            if (v.exp_valid) expect_word({v.name, "/data"});
            @(negedge clk);
            check({v.name, "/drained"},    32'(out_if.data_valid), 32'h0);
            check({v.name, "/ferr_pulse"}, 32'(frame_err), 32'h0);
        end

        // ---- overrun with a stalled consumer ----
        out_if.data_ready = 1'b0;
        sb_q.push_back(8'h11);
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("ovr/first_valid", 32'(out_if.data_valid), 32'h1);
        expect_word("ovr/first_data");
        check("ovr/first_no_ovr", 32'(overrun), 32'h0);

        // A bad frame while full must not count as an overrun.
        send_frame(1'b0, 8'h77, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("ovr/bad_ferr",    32'(frame_err), 32'h1);
        check("ovr/bad_no_ovr",  32'(overrun), 32'h0);

        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("ovr/kept_data",  32'(out_if.data_out), 32'h11);
        check("ovr/kept_valid", 32'(out_if.data_valid), 32'h1);
        check("ovr/set",        32'(overrun), 32'h1);
        pulse_clear();
        check("ovr/cleared",    32'(overrun), 32'h0);

        // clear_err coinciding with a new overrun: set wins.
        send_frame(1'b1, 8'h33, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("ovr/set_wins",   32'(overrun), 32'h1);
        check("ovr/still_11",   32'(out_if.data_out), 32'h11);
        pulse_clear();
        check("ovr/cleared2",   32'(overrun), 32'h0);

        // ---- commit coinciding with drain ----
        sb_q.push_back(8'h22);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("swap/valid",   32'(out_if.data_valid), 32'h1);
        expect_word("swap/data");
        check("swap/no_ovr",  32'(overrun), 32'h0);
        @(negedge clk);
        check("swap/drained", 32'(out_if.data_valid), 32'h0);

        // ---- reset mid-frame with a full buffer and overrun set ----
        out_if.data_ready = 1'b0;
        sb_q.push_back(8'h5A);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        expect_word("mid/pre_data");
        send_frame(1'b0, 8'h66, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("mid/pre_ovr", 32'(overrun), 32'h1);
        dir = 1'b0;
        drive_bit(START_BIT, 0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid/data_out",   32'(out_if.data_out), 32'h0);
        check("mid/data_valid", 32'(out_if.data_valid), 32'h0);
        check("mid/overrun",    32'(overrun), 32'h0);
        check("mid/frame_err",  32'(frame_err), 32'h0);
        reset = 1'b0;
        out_if.data_ready = 1'b1;
        sb_q.push_back(8'hF0);
        send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("fresh/valid",     32'(out_if.data_valid), 32'h1);
        expect_word("fresh/data");
        check("fresh/frame_err", 32'(frame_err), 32'h0);

`ifdef PARITY_CHECK_EN
        // ---- wrong parity bit discards an otherwise good frame ----
        @(negedge clk);
        par_flip = 1'b1;
        send_frame(1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        par_flip = 1'b0;
        check("par/err",       32'(parity_err), 32'h1);
        check("par/no_valid",  32'(out_if.data_valid), 32'h0);
        check("par/frame_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        check("par/pulse",     32'(parity_err), 32'h0);
`endif

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words left, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
